// File: rtl/wb_mem_ctrl.sv
// Write-back / memory-access controller: retires one ALU result per handshake as a
// register write, RAM load/store, switch/display transfer or PC redirect.
module wb_mem_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  pc,
   input  logic [4:0]  writeBackAddress,
   input  logic [31:0] result,
   input  logic [31:0] storeData,
   input  logic        isBranch,
   input  logic        isJAL,
   input  logic [1:0]  loadWrite,
   input  logic [4:0]  loadWriteAddress,
   input  logic [1:0]  inOut,
   input  logic [4:0]  inOutAddress,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        ram_re,
   output logic        ram_we,
   output logic [4:0]  ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   input  logic [31:0] io_in_data,
   input  logic        io_in_valid,
   output logic        io_in_ready,
   output logic [31:0] io_out_data,
   output logic        io_out_valid,
   input  logic        io_out_ready,
   output logic        pc_we,
   output logic [4:0]  pc_next
);

   typedef enum logic [3:0] {
      IDLE, WB, BR, LW_REQ, LW_WB, SW, IN_WAIT, IN_WR, OUT_REQ, OUT_CAP, OUT_WAIT
   } state_t;

   state_t      state;
   logic [4:0]  pc_r, wba_r, lwa_r, ioa_r;
   logic [31:0] result_r, store_r, in_data_r;
   logic        jal_r;
   logic [4:0]  pc_inc;
   logic        we_raw;

   assign pc_inc = pc_r + 5'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc_r        <= '0;
         wba_r       <= '0;
         lwa_r       <= '0;
         ioa_r       <= '0;
         result_r    <= '0;
         store_r     <= '0;
         in_data_r   <= '0;
         jal_r       <= 1'b0;
         io_out_data <= '0;
      end else begin
         case (state)
            IDLE: if (alu_valid) begin
               pc_r     <= pc;
               wba_r    <= writeBackAddress;
               lwa_r    <= loadWriteAddress;
               ioa_r    <= inOutAddress;
               result_r <= result;
               store_r  <= storeData;
               jal_r    <= isJAL;
               // branch wins over memory, memory over I/O; code 11 falls through
               if (isBranch)                state <= BR;
               else if (loadWrite == 2'b10) state <= LW_REQ;
               else if (loadWrite == 2'b01) state <= SW;
               else if (inOut == 2'b10)     state <= IN_WAIT;
               else if (inOut == 2'b01)     state <= OUT_REQ;
               else                         state <= WB;
            end
            LW_REQ:  state <= LW_WB;
            IN_WAIT: if (io_in_valid) begin
               in_data_r <= io_in_data;
               state     <= IN_WR;
            end
            OUT_REQ: state <= OUT_CAP;
            OUT_CAP: begin
               io_out_data <= ram_rdata;
               state       <= OUT_WAIT;
            end
            OUT_WAIT: if (io_out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      alu_ready    = (state == IDLE);
      we_raw       = 1'b0;
      rf_waddr     = '0;
      rf_wdata     = '0;
      ram_re       = 1'b0;
      ram_we       = 1'b0;
      ram_addr     = '0;
      ram_wdata    = '0;
      io_in_ready  = 1'b0;
      io_out_valid = 1'b0;
      pc_we        = 1'b0;
      pc_next      = (state == IDLE) ? 5'd0 : pc_inc;
      case (state)
         WB: begin
            we_raw = 1'b1; rf_waddr = wba_r; rf_wdata = result_r; pc_we = 1'b1;
         end
         BR: begin
            pc_we = 1'b1; pc_next = wba_r;
            if (jal_r) begin
               we_raw = 1'b1; rf_waddr = 5'd31; rf_wdata = {27'd0, pc_inc};
            end
         end
         LW_REQ: begin ram_re = 1'b1; ram_addr = lwa_r; end
         LW_WB: begin
            we_raw = 1'b1; rf_waddr = wba_r; rf_wdata = ram_rdata; pc_we = 1'b1;
         end
         SW: begin
            ram_we = 1'b1; ram_addr = lwa_r; ram_wdata = store_r; pc_we = 1'b1;
         end
         IN_WAIT: io_in_ready = 1'b1;
         IN_WR: begin
            ram_we = 1'b1; ram_addr = ioa_r; ram_wdata = in_data_r; pc_we = 1'b1;
         end
         OUT_REQ: begin ram_re = 1'b1; ram_addr = ioa_r; end
         OUT_WAIT: begin io_out_valid = 1'b1; pc_we = io_out_ready; end
         default: ;
      endcase
      rf_we = we_raw && (rf_waddr != 5'd0);
      // a reset cycle must not commit the instruction it is dropping
      if (rst) begin
         rf_we = 1'b0; ram_re = 1'b0; ram_we = 1'b0;
         io_in_ready = 1'b0; io_out_valid = 1'b0; pc_we = 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_mem_ctrl.sv
// Scoreboard bench for wb_mem_ctrl: stimulus queues expected strobe cycles,
// a negedge monitor compares every cycle in which the DUT asserts any strobe.
module tb_wb_mem_ctrl;
   logic        clk = 0, rst = 1, alu_valid = 0, alu_ready;
   logic [4:0]  pc = 0, writeBackAddress = 0, loadWriteAddress = 0, inOutAddress = 0;
   logic [31:0] result = 0, storeData = 0;
   logic        isBranch = 0, isJAL = 0;
   logic [1:0]  loadWrite = 0, inOut = 0;
   logic        rf_we, ram_re, ram_we, io_in_ready, io_out_valid, pc_we;
   logic [4:0]  rf_waddr, ram_addr, pc_next;
   logic [31:0] rf_wdata, ram_wdata, ram_rdata, io_out_data;
   logic [31:0] io_in_data = 0;
   logic        io_in_valid = 0, io_out_ready = 0;
   int checks = 0, failures = 0;

   typedef struct {
      logic rf_we; logic [4:0] rf_waddr; logic [31:0] rf_wdata;
      logic ram_re; logic ram_we; logic [4:0] ram_addr; logic [31:0] ram_wdata;
      logic io_in_ready; logic io_out_valid; logic [31:0] io_out_data;
      logic pc_we; logic [4:0] pc_next;
   } rec_t;
   rec_t exp_q[$];

   always #5 clk = ~clk;

   wb_mem_ctrl dut (
      .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_ready(alu_ready), .pc(pc),
      .writeBackAddress(writeBackAddress), .result(result), .storeData(storeData),
      .isBranch(isBranch), .isJAL(isJAL), .loadWrite(loadWrite),
      .loadWriteAddress(loadWriteAddress), .inOut(inOut), .inOutAddress(inOutAddress),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .io_in_data(io_in_data), .io_in_valid(io_in_valid),
      .io_in_ready(io_in_ready), .io_out_data(io_out_data), .io_out_valid(io_out_valid),
      .io_out_ready(io_out_ready), .pc_we(pc_we), .pc_next(pc_next)
   );

   // 32x32 data RAM with one-cycle read latency
   logic [31:0] mem [32];
   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      ram_rdata = 32'h0;
   end
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_addr];
   end

   function automatic rec_t mk(input logic rfwe, input logic [4:0] rfa, input logic [31:0] rfd,
                               input logic re, input logic we, input logic [4:0] ra,
                               input logic [31:0] rd, input logic inr, input logic ov,
                               input logic [31:0] od, input logic pw, input logic [4:0] pn);
      rec_t r;
      r.rf_we = rfwe; r.rf_waddr = rfa; r.rf_wdata = rfd;
      r.ram_re = re; r.ram_we = we; r.ram_addr = ra; r.ram_wdata = rd;
      r.io_in_ready = inr; r.io_out_valid = ov; r.io_out_data = od;
      r.pc_we = pw; r.pc_next = pn;
      return r;
   endfunction

   always @(negedge clk) begin
      if (rf_we || ram_re || ram_we || io_in_ready || io_out_valid || pc_we) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe t=%0t rf_we=%b ram_re=%b ram_we=%b in_rdy=%b out_vld=%b pc_we=%b required none",
                     $time, rf_we, ram_re, ram_we, io_in_ready, io_out_valid, pc_we);
         end else begin
            rec_t e;
            logic ok;
            e = exp_q.pop_front();
            ok = (rf_we == e.rf_we) && (ram_re == e.ram_re) && (ram_we == e.ram_we) &&
                 (io_in_ready == e.io_in_ready) && (io_out_valid == e.io_out_valid) &&
                 (pc_we == e.pc_we) &&
                 (!e.rf_we || (rf_waddr == e.rf_waddr && rf_wdata == e.rf_wdata)) &&
                 (!(e.ram_re || e.ram_we) || ram_addr == e.ram_addr) &&
                 (!e.ram_we || ram_wdata == e.ram_wdata) &&
                 (!e.io_out_valid || io_out_data == e.io_out_data) &&
                 (!e.pc_we || pc_next == e.pc_next);
            if (!ok) begin
               failures++;
               $display("FAIL strobe_cycle t=%0t got rf=%b/%0d/%h ram=%b%b/%0d/%h in=%b out=%b/%h pc=%b/%0d required rf=%b/%0d/%h ram=%b%b/%0d/%h in=%b out=%b/%h pc=%b/%0d",
                        $time, rf_we, rf_waddr, rf_wdata, ram_re, ram_we, ram_addr, ram_wdata,
                        io_in_ready, io_out_valid, io_out_data, pc_we, pc_next,
                        e.rf_we, e.rf_waddr, e.rf_wdata, e.ram_re, e.ram_we, e.ram_addr,
                        e.ram_wdata, e.io_in_ready, e.io_out_valid, e.io_out_data,
                        e.pc_we, e.pc_next);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s got=%h required=%h", name, act, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk_idle_zero(input string name);
      chk({name, "_alu_ready"}, {31'd0, alu_ready}, 32'd1);
      chk({name, "_strobes"}, {26'd0, rf_we, ram_re, ram_we, io_in_ready, io_out_valid, pc_we}, 32'd0);
      chk({name, "_addrs"}, {17'd0, rf_waddr, ram_addr, pc_next}, 32'd0);
      chk({name, "_rf_wdata"}, rf_wdata, 32'd0);
      chk({name, "_ram_wdata"}, ram_wdata, 32'd0);
      chk({name, "_io_out_data"}, io_out_data, 32'd0);
   endtask

   task automatic issue(input logic [4:0] p, input logic [4:0] wba, input logic [31:0] res,
                        input logic [31:0] sd, input logic br, input logic jal,
                        input logic [1:0] lw, input logic [4:0] lwa,
                        input logic [1:0] io, input logic [4:0] ioa);
      pc = p; writeBackAddress = wba; result = res; storeData = sd;
      isBranch = br; isJAL = jal; loadWrite = lw; loadWriteAddress = lwa;
      inOut = io; inOutAddress = ioa; alu_valid = 1;
      chk("alu_ready_at_issue", {31'd0, alu_ready}, 32'd1);
      @(posedge clk); #1;
      alu_valid = 0;
   endtask

   initial begin
      step(3);
      chk_idle_zero("reset");
      rst = 0;
      step(1);
      chk_idle_zero("post_reset");

      // add r5 = 7 at pc 3
      exp_q.push_back(mk(1, 5'd5, 32'd7, 0, 0, 0, 0, 0, 0, 0, 1, 5'd4));
      issue(5'd3, 5'd5, 32'd7, 0, 0, 0, 2'b00, 0, 2'b00, 0);
      chk("busy_after_accept", {31'd0, alu_ready}, 32'd0);
      step(1);
      chk("ready_cycle2", {31'd0, alu_ready}, 32'd1);

      // write to r0 suppressed, pc still advances
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd11));
      issue(5'd10, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 2'b00, 0, 2'b00, 0);
      step(1);
      // pc wraps 31 -> 0
      exp_q.push_back(mk(1, 5'd1, 32'h55, 0, 0, 0, 0, 0, 0, 0, 1, 5'd0));
      issue(5'd31, 5'd1, 32'h55, 0, 0, 0, 2'b00, 0, 2'b00, 0);
      step(1);
      // code 11 on both selects falls through to write-back
      exp_q.push_back(mk(1, 5'd7, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1, 5'd3));
      issue(5'd2, 5'd7, 32'h1234, 32'h99, 0, 0, 2'b11, 5'd8, 2'b11, 5'd8);
      step(1);

      // sw then lw of the same word
      exp_q.push_back(mk(0, 0, 0, 0, 1, 5'd9, 32'hDEAD_BEEF, 0, 0, 0, 1, 5'd13));
      issue(5'd12, 5'd0, 0, 32'hDEAD_BEEF, 0, 0, 2'b01, 5'd9, 2'b00, 0);
      step(1);
      exp_q.push_back(mk(0, 0, 0, 1, 0, 5'd9, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(1, 5'd4, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 1, 5'd14));
      issue(5'd13, 5'd4, 0, 0, 0, 0, 2'b10, 5'd9, 2'b00, 0);
      step(1);
      chk("lw_still_busy", {31'd0, alu_ready}, 32'd0);
      step(1);
      chk("lw_ready", {31'd0, alu_ready}, 32'd1);

      // jal 12 from pc 6
      exp_q.push_back(mk(1, 5'd31, 32'd7, 0, 0, 0, 0, 0, 0, 0, 1, 5'd12));
      issue(5'd6, 5'd12, 32'h0, 0, 1, 1, 2'b00, 0, 2'b00, 0);
      step(1);

      // in to address 2 after three idle cycles of the switch
      repeat (4) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 1, 5'd2, 32'hA5, 0, 0, 0, 1, 5'd21));
      io_in_valid = 1; io_in_data = 32'hBAD;  // ignored outside IN_WAIT
      issue(5'd20, 5'd0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 5'd2);
      io_in_valid = 0; io_in_data = 0;
      step(3);
      io_in_valid = 1; io_in_data = 32'hA5;
      step(1);
      io_in_valid = 0; io_in_data = 0;
      step(1);
      chk("in_ready_back", {31'd0, alu_ready}, 32'd1);

      // out from address 2, display stalls two cycles
      exp_q.push_back(mk(0, 0, 0, 1, 0, 5'd2, 0, 0, 0, 0, 0, 0));
      repeat (2) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5, 1, 5'd22));
      io_out_ready = 1;  // ignored outside OUT_WAIT
      issue(5'd21, 5'd0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 5'd2);
      io_out_ready = 0;
      step(4);
      io_out_ready = 1;
      step(1);
      io_out_ready = 0;
      chk("out_ready_back", {31'd0, alu_ready}, 32'd1);

      // reset during LW_WB drops the load
      exp_q.push_back(mk(0, 0, 0, 1, 0, 5'd9, 0, 0, 0, 0, 0, 0));
      issue(5'd1, 5'd4, 0, 0, 0, 0, 2'b10, 5'd9, 2'b00, 0);
      step(1);
      rst = 1;
      step(1);
      rst = 0;
      chk_idle_zero("rst_lw_wb");

      // reset during OUT_WAIT with the display ready
      exp_q.push_back(mk(0, 0, 0, 1, 0, 5'd2, 0, 0, 0, 0, 0, 0));
      issue(5'd1, 5'd0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 5'd2);
      step(2);
      io_out_ready = 1; rst = 1;
      step(1);
      io_out_ready = 0; rst = 0;
      chk_idle_zero("rst_out_wait");

      // branch outranks a load
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd17));
      issue(5'd8, 5'd17, 0, 0, 1, 0, 2'b10, 5'd9, 2'b00, 0);
      step(1);
      chk("br_ready", {31'd0, alu_ready}, 32'd1);

      step(2);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_mem_ctrl.md
# wb_mem_ctrl

Write-back / memory-access controller consuming the ALU's per-instruction outputs: the receiving end of the ALU result interface. It accepts one ALU result per handshake and carries it out as one of the following:
- a register-file write;
- a data-RAM load or store;
- a display/switch I/O transfer;
- a PC redirect.

It then advances the PC and signals ready for the next instruction. It sits between the ALU and the 32×32 register file, 32×32 data RAM and I/O port.

## Interface
Parameters: none (5-bit addresses, 32-bit data fixed by the CPU).
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU outputs below are valid this cycle
- alu_ready  out  1  controller can accept (high only in IDLE)
- pc  in  5  PC of the instruction being retired
- writeBackAddress  in  5  rd / lw destination / branch-jump target
- result  in  32  ALU result
- storeData  in  32  sw data (rt value)
- isBranch, isJAL  in  1 each  branch/jump taken; jal link
- loadWrite  in  2  10 lw, 01 sw, else none
- loadWriteAddress  in  5  RAM address for lw/sw
- inOut  in  2  10 in, 01 out, else none
- inOutAddress  in  5  RAM address for in/out
- rf_we  out  1; rf_waddr  out  5; rf_wdata  out  32  register-file write port
- ram_re, ram_we  out  1 each; ram_addr  out  5; ram_wdata  out  32; ram_rdata  in  32 (valid the cycle after ram_re)
- io_in_data  in  32; io_in_valid  in  1; io_in_ready  out  1  switch input handshake
- io_out_data  out  32; io_out_valid  out  1; io_out_ready  in  1  display output handshake
- pc_we  out  1; pc_next  out  5  PC update strobe and value

## Operation
- Accept when alu_valid && alu_ready; register every input field.
- Decode priority: isBranch > loadWrite (10/01) > inOut (10/01) > plain write-back. Codes 11 are treated as 00.
- FSM states: IDLE, WB, BR, LW_REQ, LW_WB, SW, IN_WAIT, IN_WR, OUT_REQ, OUT_CAP, OUT_WAIT.
- The next state is chosen at accept; in IDLE every strobe is 0.
- WB: rf_we=1, rf_waddr=writeBackAddress, rf_wdata=result.
- BR: pc_next=writeBackAddress. If isJAL, rf_we=1, rf_waddr=31, rf_wdata=pc+1 (zero-extended).
- LW_REQ: ram_re=1, ram_addr=loadWriteAddress.
- LW_WB: rf_we=1, rf_waddr=writeBackAddress, rf_wdata=ram_rdata.
- SW: ram_we=1, ram_addr=loadWriteAddress, ram_wdata=storeData.
- IN_WAIT: io_in_ready=1. Stays in IN_WAIT until io_in_valid is sampled high, then captures io_in_data.
- IN_WR: ram_we=1, ram_addr=inOutAddress, ram_wdata=captured data.
- OUT_REQ: ram_re=1, ram_addr=inOutAddress.
- OUT_CAP: io_out_data <= ram_rdata.
- OUT_WAIT: io_out_valid=1 and io_out_data held stable until io_out_ready is high.
- Terminal states are WB, BR, LW_WB, SW, IN_WR, and OUT_WAIT on the cycle io_out_ready=1. In a terminal state, pc_we=1 and the FSM returns to IDLE next cycle.
- pc_next is pc+1 mod 32 (31→0) except in BR.
- rf_we is forced 0 whenever rf_waddr==0. This does not apply to the jal link, since its address is 31.
- Strobes other than those listed per state are 0.

## Timing
- Reset, and the value of every output after reset:
  - state=IDLE;
  - alu_ready=1;
  - every strobe, valid and ready output 0;
  - every address/data output 0, including io_out_data and pc_next.
- Reset mid-operation drops the instruction with no pending write and no pc_we.
- Strobes are decoded from registered state (Moore), with one exception: pc_we in OUT_WAIT, which follows io_out_ready combinationally.
- Busy cycles after accept, until alu_ready returns:
  - WB/BR/SW: 1
  - lw: 2
  - in: 1 + wait + 1
  - out: 2 + wait + 1
- Minimum back-to-back rate: one accept every 2 cycles.
- alu_valid while busy is ignored; the ALU holds its outputs until accepted.
- io_in_valid outside IN_WAIT is ignored. io_out_ready outside OUT_WAIT is ignored.

## Test plan
- Reset, then ALU add: writeBackAddress=5, result=0x0000_0007, pc=3.
  - Cycle 1: rf_we=1, rf_waddr=5, rf_wdata=7, pc_we=1, pc_next=4.
  - alu_ready=1 in cycle 2.
- Write-back with writeBackAddress=0, result=0xFFFF_FFFF → rf_we stays 0, pc_we=1. Then pc=31 with a plain op → pc_next=0.
- sw storeData=0xDEAD_BEEF, loadWriteAddress=9, then lw loadWriteAddress=9, writeBackAddress=4.
  - sw: ram_we at addr 9.
  - lw: ram_re, then the next cycle rf_wdata=0xDEAD_BEEF to r4.
- jal: isBranch=1, isJAL=1, writeBackAddress=12, pc=6 → single cycle: pc_next=12, rf_we with r31 = 7.
- in to address 2, io_in_valid held low 3 cycles then high with 0x0000_00A5 → io_in_ready high through the wait, then ram_we addr 2 data 0xA5. Follow with out from address 2 and io_out_ready low 2 cycles → io_out_valid=1 with 0xA5 held stable, pc_we only on the ready cycle.
- Assert rst in LW_WB and in OUT_WAIT → no rf_we / pc_we. Next cycle: IDLE with all outputs 0. isBranch plus loadWrite=10 → treated as branch, no RAM access.
